l2_controller: RTL

Unified L2 cache controller serving as the responder side of the L1↔L2 request interface. It accepts level-held read/write requests from an L1 controller and answers each with a one-cycle `ready_L2_L1` pulse. On a miss it fetches the line from main memory, writing back a dirty victim first when one exists. It owns the L2 tag/valid/dirty arrays (direct-mapped) and drives strobes to an external L2 data array.

---
 rtl/l2_controller_if.sv | 30 +++
 rtl/l2_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/l2_controller_if.sv
// rtl/l2_controller_if.sv - L1<->L2 request and L2<->memory bus bundle
interface l2_controller_if #(
   parameter int ADDR_W = 58
);
   logic [ADDR_W-1:0] addr_L1_L2;
   logic              read_L1_L2;
   logic              write_L1_L2;
   logic              ready_L2_L1;
   logic              read_L2_MEM;
   logic              write_L2_MEM;
   logic [ADDR_W-1:0] addr_L2_MEM;
   logic              ready_MEM_L2;
   logic              refill;
   logic              update;
   logic              stall;

   // Controller side: answers L1 requests, issues memory transactions
   modport slave (
      input  addr_L1_L2, read_L1_L2, write_L1_L2, ready_MEM_L2,
      output ready_L2_L1, read_L2_MEM, write_L2_MEM, addr_L2_MEM,
             refill, update, stall
   );

   // Environment side: L1 requester plus memory responder
   modport master (
      output addr_L1_L2, read_L1_L2, write_L1_L2, ready_MEM_L2,
      input  ready_L2_L1, read_L2_MEM, write_L2_MEM, addr_L2_MEM,
             refill, update, stall
   );
endinterface

// File: rtl/l2_controller.sv
// rtl/l2_controller.sv - direct-mapped L2 cache controller; L2_WRITEBACK_EN selects write-back, else write-through
module l2_controller #(
   parameter int ADDR_W  = 58,
   parameter int INDEX_W = 8
) (
   input  logic            clk,
   input  logic            nrst,
   l2_controller_if.slave  bus
);
   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int SETS  = 1 << INDEX_W;

`ifdef L2_WRITEBACK_EN
   typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND} state_t;
`else
   // WRITETHRU forwards every L1 write to memory before responding
   typedef enum logic [2:0] {IDLE, COMPARE, WRITETHRU, ALLOCATE, RESPOND} state_t;
`endif

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W-1:0]  r_addr;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic               r_is_write;
   logic               r_refill;
   logic               r_update;
   logic [SETS-1:0]    r_valid;
   logic [TAG_W-1:0]   r_tag [SETS];
`ifdef L2_WRITEBACK_EN
   logic [SETS-1:0]    r_dirty;
`endif

   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_tag;
   logic               w_hit;
   logic               w_req;
   logic               w_ready_l1;
   logic               w_rd_mem;
   logic               w_wr_mem;

   assign w_idx = r_addr[INDEX_W-1:0];
   assign w_tag = r_addr[ADDR_W-1:INDEX_W];
   assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_req = bus.read_L1_L2 | bus.write_L1_L2;

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and state-decoded outputs; nothing here depends combinationally on inputs reaching outputs
   always_comb begin
      w_next     = r_state;
      w_ready_l1 = 1'b0;
      w_rd_mem   = 1'b0;
      w_wr_mem   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) w_next = COMPARE;
         end
         COMPARE: begin
`ifdef L2_WRITEBACK_EN
            if (w_hit)                                w_next = RESPOND;
            else if (r_valid[w_idx] && r_dirty[w_idx]) w_next = WRITEBACK;
            else                                      w_next = ALLOCATE;
`else
            if (r_is_write)  w_next = WRITETHRU;
            else if (w_hit)  w_next = RESPOND;
            else             w_next = ALLOCATE;
`endif
         end
`ifdef L2_WRITEBACK_EN
         WRITEBACK: begin
            w_wr_mem = 1'b1;
            if (bus.ready_MEM_L2) w_next = ALLOCATE;
         end
`else
         WRITETHRU: begin
            w_wr_mem = 1'b1;
            if (bus.ready_MEM_L2) w_next = RESPOND;
         end
`endif
         ALLOCATE: begin
            w_rd_mem = 1'b1;
            // Return to COMPARE so the re-lookup takes the ordinary hit path
            if (bus.ready_MEM_L2) w_next = COMPARE;
         end
         RESPOND: begin
            w_ready_l1 = 1'b1;
            w_next     = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Request latch, memory address, valid bits and the one-cycle data-array strobes
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_addr     <= '0;
         r_is_write <= 1'b0;
         r_mem_addr <= '0;
         r_refill   <= 1'b0;
         r_update   <= 1'b0;
         r_valid    <= '0;
      end else begin
         r_refill <= 1'b0;
         r_update <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_addr     <= bus.addr_L1_L2;
                  r_is_write <= bus.write_L1_L2;
               end
            end
            COMPARE: begin
               r_update <= w_hit && r_is_write;
`ifdef L2_WRITEBACK_EN
               if (w_next == WRITEBACK)     r_mem_addr <= {r_tag[w_idx], w_idx};
               else if (w_next == ALLOCATE) r_mem_addr <= r_addr;
`else
               if (w_next != RESPOND)       r_mem_addr <= r_addr;
`endif
            end
`ifdef L2_WRITEBACK_EN
            WRITEBACK: begin
               if (bus.ready_MEM_L2) r_mem_addr <= r_addr;
            end
`endif
            ALLOCATE: begin
               if (bus.ready_MEM_L2) begin
                  r_refill       <= 1'b1;
                  r_valid[w_idx] <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Tag array carries no reset; valid bits alone decide whether an entry is meaningful
   always_ff @(posedge clk) begin
      if (r_state == ALLOCATE && bus.ready_MEM_L2) begin
         r_tag[w_idx] <= w_tag;
      end
   end

`ifdef L2_WRITEBACK_EN
   // Dirty bits: set by an L1 write hit, cleared once the victim reaches memory
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_dirty <= '0;
      end else if (r_state == COMPARE && w_hit && r_is_write) begin
         r_dirty[w_idx] <= 1'b1;
      end else if (r_state == WRITEBACK && bus.ready_MEM_L2) begin
         r_dirty[w_idx] <= 1'b0;
      end
   end
`endif

   assign bus.ready_L2_L1  = w_ready_l1;
   assign bus.read_L2_MEM  = w_rd_mem;
   assign bus.write_L2_MEM = w_wr_mem;
   assign bus.addr_L2_MEM  = r_mem_addr;
   assign bus.refill       = r_refill;
   assign bus.update       = r_update;
   assign bus.stall        = (r_state != IDLE);
endmodule
